// File: rtl/pkt_flow_prior_if.sv
// Bundle of the key-in / tagged-key-out handshake signals of the flow priority tagger.
// Handshake semantics:
//   input side : a key is pushed on a rising edge when in_en && in_valid; in_valid is high while the
//                FIFO has room and does not depend on in_en.
//   output side: the result in out_key/out_prior/out_hit is consumed on a rising edge when
//                out_valid && out_ready; while out_valid && !out_ready the result holds still.
interface pkt_flow_prior_if #(
  parameter int KEY_W = 96,
  parameter int CNT_W = 6
);
  logic             in_en;
  logic             in_valid;
  logic [KEY_W-1:0] in_key;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [KEY_W-1:0] out_key;
  logic [CNT_W-1:0] out_prior;
  logic             out_hit;
  logic [15:0]      drop_cnt;

  // Traffic source / consumer side
  modport master (
    output in_en, in_key, flush, out_ready,
    input  in_valid, out_valid, out_key, out_prior, out_hit, drop_cnt
  );

  // Tagger side
  modport slave (
    input  in_en, in_key, flush, out_ready,
    output in_valid, out_valid, out_key, out_prior, out_hit, drop_cnt
  );
endinterface

// File: rtl/pkt_flow_prior.sv
// Per-flow priority tagger: keys are buffered in a FIFO, matched against a small flow table holding a
// saturating packet count per flow, and emitted with a priority derived from the updated count.
module pkt_flow_prior #(
  parameter int KEY_W      = 96,
  parameter int SLOT_SIZE  = 8,
  parameter int CNT_W      = 6,
  parameter int FIFO_DEPTH = 16,
  parameter int PRIOR_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  pkt_flow_prior_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SLOT_SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Input FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [KEY_W-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [KEY_W-1:0] w_head;

  // Flow table
  logic [SLOT_SIZE-1:0] r_slot_valid;
  logic [KEY_W-1:0]     r_slot_key [SLOT_SIZE];
  logic [CNT_W-1:0]     r_slot_cnt [SLOT_SIZE];
  logic [SW-1:0]        r_rr_ptr;

  // Lookup results
  logic             w_hit;
  logic [SW-1:0]    w_hit_idx;
  logic             w_free;
  logic [SW-1:0]    w_free_idx;
  logic [SW-1:0]    w_tgt_idx;
  logic [SW-1:0]    w_rr_next;
  logic [CNT_W-1:0] w_new_cnt;
  logic [CNT_W-1:0] w_new_prior;

  // Output register and drop counter
  logic             r_out_valid;
  logic [KEY_W-1:0] r_out_key;
  logic [CNT_W-1:0] r_out_prior;
  logic             r_out_hit;
  logic [15:0]      r_drop_cnt;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A full FIFO rejects the push even when a pop frees an entry on the same edge.
  assign w_push  = bus.in_en && !w_full;
  // flush owns the table on its edge, so the pop waits one cycle.
  assign w_pop   = !w_empty && (!r_out_valid || bus.out_ready) && !bus.flush;
  assign w_head  = r_fifo_mem[r_rd_ptr[AW-1:0]];

  // Lowest-index valid slot whose key equals the FIFO head
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = SLOT_SIZE - 1; i >= 0; i--) begin
      if (r_slot_valid[i] && (r_slot_key[i] == w_head)) begin
        w_hit     = 1'b1;
        w_hit_idx = SW'(i);
      end
    end
  end

  // Lowest-index invalid slot, used for allocation on a miss
  always_comb begin
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = SLOT_SIZE - 1; i >= 0; i--) begin
      if (!r_slot_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = SW'(i);
      end
    end
  end

  // Choose the slot to write and the count it receives
  always_comb begin
    w_rr_next = (r_rr_ptr == SW'(SLOT_SIZE - 1)) ? '0 : r_rr_ptr + 1'b1;
    if (w_hit) begin
      w_tgt_idx = w_hit_idx;
      w_new_cnt = (r_slot_cnt[w_hit_idx] == CNT_MAX) ? CNT_MAX : r_slot_cnt[w_hit_idx] + 1'b1;
    end else begin
      w_tgt_idx = w_free ? w_free_idx : r_rr_ptr;
      w_new_cnt = CNT_W'(1);
    end
    w_new_prior = (PRIOR_MODE != 0) ? ~w_new_cnt : w_new_cnt;
  end

  // FIFO storage write (contents need no reset; emptiness lives in the pointers)
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr[AW-1:0]] <= bus.in_key;
  end

  // FIFO pointers and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (bus.in_en && w_full && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Flow table update: flush clears, a pop bumps a hit or installs a new flow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_valid <= '0;
      r_rr_ptr     <= '0;
      for (int i = 0; i < SLOT_SIZE; i++) begin
        r_slot_key[i] <= '0;
        r_slot_cnt[i] <= '0;
      end
    end else if (bus.flush) begin
      r_slot_valid <= '0;
      r_rr_ptr     <= '0;
    end else if (w_pop) begin
      r_slot_valid[w_tgt_idx] <= 1'b1;
      r_slot_key[w_tgt_idx]   <= w_head;
      r_slot_cnt[w_tgt_idx]   <= w_new_cnt;
      // Round-robin pointer moves only when a valid flow is evicted
      if (!w_hit && !w_free) r_rr_ptr <= w_rr_next;
    end
  end

  // Output register: load on pop, clear valid after an accepted handshake with no refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_key   <= '0;
      r_out_prior <= '0;
      r_out_hit   <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_key   <= w_head;
      r_out_prior <= w_new_prior;
      r_out_hit   <= w_hit;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_valid  = !w_full;
  assign bus.out_valid = r_out_valid;
  assign bus.out_key   = r_out_key;
  assign bus.out_prior = r_out_prior;
  assign bus.out_hit   = r_out_hit;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule
